// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - sequential ALU: single-cycle logic/arith ops, W-cycle shift-add multiply
module alu_seq #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [2:0]   control,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic         carryin,
  output logic [W-1:0] out,
  output logic [W-1:0] out_hi,
  output logic         carryout,
  output logic         overflow,
  output logic         zero,
  output logic         negative,
  output logic         busy,
  output logic         done
);

  localparam logic [2:0] OP_MUL = 3'd0;
  localparam logic [2:0] OP_SLT = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_SUB = 3'd3;
  localparam logic [2:0] OP_AND = 3'd4;
  localparam logic [2:0] OP_OR  = 3'd5;
  localparam logic [2:0] OP_NOR = 3'd6;
  localparam logic [2:0] OP_XOR = 3'd7;

  localparam int CW = $clog2(W);

  typedef enum logic {IDLE, MUL} state_t;

  state_t         state;
  logic [W-1:0]   mcand;
  logic [2*W-1:0] prod;
  logic [CW-1:0]  cnt;

  logic [W-1:0]   res;
  logic           res_co;
  logic           res_ov;
  logic [W:0]     sum_w;

  logic [W-1:0]   addend;
  logic [W:0]     step_sum;
  logic [2*W-1:0] prod_next;

  always_comb begin
    res    = '0;
    res_co = 1'b0;
    res_ov = 1'b0;
    sum_w  = '0;
    case (control)
      OP_SLT: res = {{(W-1){1'b0}}, ($signed(A) < $signed(B))};
      OP_ADD: begin
        sum_w  = {1'b0, A} + {1'b0, B} + {{W{1'b0}}, carryin};
        res    = sum_w[W-1:0];
        res_co = sum_w[W];
        res_ov = (A[W-1] == B[W-1]) && (res[W-1] != A[W-1]);
      end
      OP_SUB: begin
        sum_w  = {1'b0, A} + {1'b0, ~B} + {{W{1'b0}}, 1'b1};
        res    = sum_w[W-1:0];
        res_co = sum_w[W];
        res_ov = (A[W-1] != B[W-1]) && (res[W-1] != A[W-1]);
      end
      OP_AND: res = A & B;
      OP_OR:  res = A | B;
      OP_NOR: res = ~(A | B);
      OP_XOR: res = A ^ B;
      default: res = '0;
    endcase
  end

  // Multiplier lives in prod[W-1:0] and is shifted out as the product shifts in.
  always_comb begin
    addend    = prod[0] ? mcand : '0;
    step_sum  = {1'b0, prod[2*W-1:W]} + {1'b0, addend};
    prod_next = {step_sum, prod[W-1:1]};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      mcand    <= '0;
      prod     <= '0;
      cnt      <= '0;
      out      <= '0;
      out_hi   <= '0;
      carryout <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
      negative <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (control == OP_MUL) begin
              mcand <= A;
              prod  <= {{W{1'b0}}, B};
              cnt   <= '0;
              busy  <= 1'b1;
              state <= MUL;
            end else begin
              out      <= res;
              out_hi   <= '0;
              carryout <= res_co;
              overflow <= res_ov;
              zero     <= (res == '0);
              negative <= res[W-1];
              done     <= 1'b1;
            end
          end
        end
        MUL: begin
          prod <= prod_next;
          cnt  <= cnt + 1'b1;
          if (cnt == CW'(W - 1)) begin
            out      <= prod_next[W-1:0];
            out_hi   <= prod_next[2*W-1:W];
            carryout <= (prod_next[2*W-1:W] != '0);
            overflow <= 1'b0;
            zero     <= (prod_next == '0);
            negative <= prod_next[2*W-1];
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - randomized self-checking bench for alu_seq (W=8)
module tb_alu_seq;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [2:0]   control;
  logic [W-1:0] A, B;
  logic         carryin;
  logic [W-1:0] out, out_hi;
  logic         carryout, overflow, zero, negative, busy, done;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [7:0] o;
    logic [7:0] hi;
    logic       co;
    logic       ov;
    logic       z;
    logic       n;
  } res_t;

  alu_seq #(.W(W)) dut (
    .clk(clk), .reset(reset), .start(start), .control(control),
    .A(A), .B(B), .carryin(carryin),
    .out(out), .out_hi(out_hi), .carryout(carryout), .overflow(overflow),
    .zero(zero), .negative(negative), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic res_t model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                                 input logic ci);
    res_t r;
    int sa, sb, s, u;
    logic [15:0] p;
    sa = int'($signed(a));
    sb = int'($signed(b));
    r  = '0;
    case (op)
      3'd0: begin
        p = 16'(a) * 16'(b);
        r.o = p[7:0]; r.hi = p[15:8];
        r.co = (p[15:8] != 0); r.z = (p == 0); r.n = p[15];
        return r;
      end
      3'd1: r.o = (sa < sb) ? 8'd1 : 8'd0;
      3'd2: begin
        u = int'(a) + int'(b) + int'(ci);
        s = sa + sb + int'(ci);
        r.o = u[7:0]; r.co = (u > 255); r.ov = (s > 127) || (s < -128);
      end
      3'd3: begin
        u = int'(a) - int'(b);
        s = sa - sb;
        r.o = u[7:0]; r.co = (a >= b); r.ov = (s > 127) || (s < -128);
      end
      3'd4: r.o = a & b;
      3'd5: r.o = a | b;
      3'd6: r.o = ~(a | b);
      default: r.o = a ^ b;
    endcase
    r.z = (r.o == 0);
    r.n = r.o[7];
    return r;
  endfunction

  task automatic check_res(input string tag, input res_t e);
    check({tag, ".out"}, out, e.o);
    check({tag, ".hi"}, out_hi, e.hi);
    check({tag, ".co"}, carryout, e.co);
    check({tag, ".ov"}, overflow, e.ov);
    check({tag, ".z"}, zero, e.z);
    check({tag, ".n"}, negative, e.n);
  endtask

  // Issues one op, waits for its done and checks the registered results and the hold afterwards.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic ci, input bit inject);
    res_t e;
    int n;
    e = model(op, a, b, ci);
    @(negedge clk);
    start = 1'b1; control = op; A = a; B = b; carryin = ci;
    @(negedge clk);
    start = 1'b0;
    if (op != 3'd0) begin
      check({tag, ".done"}, done, 1'b1);
      check({tag, ".busy"}, busy, 1'b0);
    end else begin
      check({tag, ".busy0"}, busy, 1'b1);
      check({tag, ".done0"}, done, 1'b0);
      n = 0;
      while (busy && n < 20) begin
        n++;
        if (done) check({tag, ".done_busy"}, done, 1'b0);
        if (inject && n == 3) begin
          start = 1'b1; control = 3'd2; A = $urandom; B = $urandom; carryin = 1'b1;
        end else if (inject && n == 4) begin
          start = 1'b0; A = $urandom; B = $urandom;
        end
        @(negedge clk);
      end
      check({tag, ".busy_cycles"}, n, W);
      check({tag, ".done"}, done, 1'b1);
    end
    check_res(tag, e);
    @(negedge clk);
    check({tag, ".done_pulse"}, done, 1'b0);
    check({tag, ".hold"}, out, e.o);
  endtask

  initial begin
    res_t e;
    reset = 1'b0; start = 1'b0; control = 3'd0; A = '0; B = '0; carryin = 1'b0;
    #1;
    check_res("rst", '0);
    check("rst.busy", busy, 1'b0);
    check("rst.done", done, 1'b0);
    @(negedge clk);
    reset = 1'b1;

    run_op("add_ff01", 3'd2, 8'hFF, 8'h01, 1'b0, 1'b0);
    run_op("sub_8001", 3'd3, 8'h80, 8'h01, 1'b0, 1'b0);
    run_op("slt_807f", 3'd1, 8'h80, 8'h7F, 1'b0, 1'b0);
    run_op("mul_ffff", 3'd0, 8'hFF, 8'hFF, 1'b0, 1'b1);
    run_op("mul_15_17", 3'd0, 8'd15, 8'd17, 1'b0, 1'b0);
    run_op("and_0ff0", 3'd4, 8'h0F, 8'hF0, 1'b0, 1'b0);

    // Reset in the middle of a multiply, asserted between clock edges.
    @(negedge clk);
    start = 1'b1; control = 3'd0; A = 8'hC3; B = 8'h5A;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check_res("midrst", '0);
    check("midrst.busy", busy, 1'b0);
    check("midrst.done", done, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    run_op("add_after_rst", 3'd2, 8'h05, 8'h03, 1'b1, 1'b0);

    // Back-to-back single-cycle ops on consecutive edges.
    @(negedge clk);
    start = 1'b1; control = 3'd7; A = 8'hAA; B = 8'hFF; carryin = 1'b0;
    @(negedge clk);
    check("b2b.xor.done", done, 1'b1);
    check("b2b.xor.out", out, 8'h55);
    control = 3'd6; A = 8'h00; B = 8'h00;
    @(negedge clk);
    start = 1'b0;
    check("b2b.nor.done", done, 1'b1);
    check("b2b.nor.out", out, 8'hFF);
    check("b2b.nor.z", zero, 1'b0);
    @(negedge clk);
    check("b2b.end.done", done, 1'b0);

    for (int i = 0; i < 60; i++) begin
      logic [2:0] op;
      op = 3'($urandom_range(0, 7));
      run_op($sformatf("rnd%0d_op%0d", i, op), op, 8'($urandom), 8'($urandom),
             1'($urandom), (i % 5) == 0);
    end

    e = model(3'd3, 8'h00, 8'h00, 1'b0);
    run_op("sub_zero", 3'd3, 8'h00, 8'h00, 1'b1, 1'b0);
    check("sub_zero.model_co", e.co, carryout);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
